// File: rtl/collision_score.sv
// -----------------------------------------------------------------------------
// collision_score
//   Game-state controller for a one-obstacle dodging game. It evaluates the
//   player and obstacle bounding boxes once per frame strobe, counts cleared
//   obstacles, tracks lives and sequences the IDLE / PLAY / HIT / OVER states.
//
// Parameters
//   LIVES      lives loaded at game start (1-3)
//   HIT_FRAMES frames the game stays frozen after a hit (1-255)
//   SCORE_W    score counter width
//
// Ports
//   i_clk                 base clock, sole clock domain
//   i_rst_n               asynchronous active-low reset
//   i_ani_stb             one-cycle frame strobe; decisions happen only here
//   i_start               start/restart request, sampled on strobe cycles
//   i_ob_x1/x2/y1/y2      obstacle box (left, right, top, bottom)
//   i_pl_x1/x2/y1/y2      player box (left, right, top, bottom)
//   o_animate             high while playing; enables obstacle motion
//   o_obs_rst             one-clock pulse sending the obstacle to its start
//   o_score               obstacles cleared this game (saturating)
//   o_lives               lives remaining
//   o_hit                 high while frozen after a hit
//   o_game_over           high once all lives are spent
// All outputs are registered and change on the clock after the deciding strobe.
// -----------------------------------------------------------------------------
module collision_score #(
   parameter int LIVES      = 3,
   parameter int HIT_FRAMES = 60,
   parameter int SCORE_W    = 10
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_ani_stb,
   input  logic               i_start,
   input  logic [11:0]        i_ob_x1,
   input  logic [11:0]        i_ob_x2,
   input  logic [11:0]        i_ob_y1,
   input  logic [11:0]        i_ob_y2,
   input  logic [11:0]        i_pl_x1,
   input  logic [11:0]        i_pl_x2,
   input  logic [11:0]        i_pl_y1,
   input  logic [11:0]        i_pl_y2,
   output logic               o_animate,
   output logic               o_obs_rst,
   output logic [SCORE_W-1:0] o_score,
   output logic [1:0]         o_lives,
   output logic               o_hit,
   output logic               o_game_over
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PLAY,
      S_HIT,
      S_OVER
   } state_t;

   localparam logic [1:0] LIVES_INIT = 2'(LIVES);
   localparam logic [7:0] HIT_INIT   = 8'(HIT_FRAMES);

   state_t             state_q,     state_d;
   logic [SCORE_W-1:0] score_q,     score_d;
   logic [1:0]         lives_q,     lives_d;
   logic [7:0]         timer_q,     timer_d;
   logic               prev_past_q, prev_past_d;
   logic               obs_rst_q,   obs_rst_d;
   logic               animate_q,   animate_d;
   logic               hit_q,       hit_d;
   logic               over_q,      over_d;

   // ---------------------------------------------------------------------------
   // Geometry. An obstacle whose left edge has wrapped past the screen edge
   // (x1 > x2) is clipped to start at column 0 and is never counted as past.
   // ---------------------------------------------------------------------------
   logic        ob_wrap;
   logic [11:0] ob_x1_eff;
   logic        overlap;
   logic        past;

   assign ob_wrap   = (i_ob_x1 > i_ob_x2);
   assign ob_x1_eff = ob_wrap ? 12'd0 : i_ob_x1;
   assign overlap   = (ob_x1_eff <= i_pl_x2) && (i_pl_x1 <= i_ob_x2) &&
                      (i_ob_y1   <= i_pl_y2) && (i_pl_y1 <= i_ob_y2);
   assign past      = !ob_wrap && (ob_x1_eff > i_pl_x2);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any branch; a path that
      // leaves one unassigned would infer a latch.
      state_d     = state_q;
      score_d     = score_q;
      lives_d     = lives_q;
      timer_d     = timer_q;
      prev_past_d = prev_past_q;
      obs_rst_d   = 1'b0;

      if (i_ani_stb) begin
         unique case (state_q)
            S_IDLE, S_OVER: begin
               if (i_start) begin
                  state_d     = S_PLAY;
                  score_d     = '0;
                  lives_d     = LIVES_INIT;
                  timer_d     = 8'd0;
                  prev_past_d = 1'b0;
                  obs_rst_d   = 1'b1;
               end
            end

            S_PLAY: begin
               prev_past_d = past;
               if (overlap) begin
                  // A hit takes priority over a simultaneous pass.
                  state_d = S_HIT;
                  timer_d = HIT_INIT;
                  if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
               end else if (past && !prev_past_q && !(&score_q)) begin
                  score_d = score_q + SCORE_W'(1);
               end
            end

            S_HIT: begin
               if (timer_q != 8'd0) timer_d = timer_q - 8'd1;
               if (timer_q == 8'd1) begin
                  if (lives_q == 2'd0) begin
                     state_d = S_OVER;
                  end else begin
                     state_d     = S_PLAY;
                     prev_past_d = 1'b0;
                     obs_rst_d   = 1'b1;
                  end
               end
            end

            default: state_d = S_IDLE;
         endcase
      end

      // Status flags follow the next state so they are valid from a flop.
      animate_d = (state_d == S_PLAY);
      hit_d     = (state_d == S_HIT);
      over_d    = (state_d == S_OVER);
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         score_q     <= '0;
         lives_q     <= LIVES_INIT;
         timer_q     <= 8'd0;
         prev_past_q <= 1'b0;
         obs_rst_q   <= 1'b0;
         animate_q   <= 1'b0;
         hit_q       <= 1'b0;
         over_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         score_q     <= score_d;
         lives_q     <= lives_d;
         timer_q     <= timer_d;
         prev_past_q <= prev_past_d;
         obs_rst_q   <= obs_rst_d;
         animate_q   <= animate_d;
         hit_q       <= hit_d;
         over_q      <= over_d;
      end
   end

   assign o_animate   = animate_q;
   assign o_obs_rst   = obs_rst_q;
   assign o_score     = score_q;
   assign o_lives     = lives_q;
   assign o_hit       = hit_q;
   assign o_game_over = over_q;

endmodule
